// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 slave memory model for interconnect bring-up.
// Write and read channels run independent FSMs over one shared,
// byte-addressable array. Beats are always full width. FIXED, INCR and
// WRAP bursts are supported. A reserved burst type, or a WRAP burst with an
// unsupported length, still runs its full beat count. Such a burst never
// changes the array and reports SLVERR.
module axi_ram_slave #(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int RAM_ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  // write address channel
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // write response channel
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // read address channel
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // read data channel
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int WORD_BITS  = RAM_ADDR_WIDTH - ADDR_LSB;
  localparam int WORDS      = 2 ** WORD_BITS;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;

  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_BURST = 1'b1;

  // Reserved burst type, or a WRAP whose beat count is not 2, 4, 8 or 16.
  function automatic logic burst_illegal(input logic [1:0] burst,
                                         input logic [7:0] len);
    logic bad;
    bad = 1'b0;
    if (burst == BURST_RSVD) begin
      bad = 1'b1;
    end else if (burst == BURST_WRAP) begin
      bad = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    end
    return bad;
  endfunction

  // Address of the beat after addr. INCR rolls over at the top of the store.
  // WRAP stays inside the (len+1)-beat aligned window.
  function automatic logic [RAM_ADDR_WIDTH-1:0] next_addr(
      input logic [RAM_ADDR_WIDTH-1:0] addr,
      input logic [7:0]                len,
      input logic [1:0]                burst);
    logic [RAM_ADDR_WIDTH-1:0] step;
    logic [RAM_ADDR_WIDTH-1:0] mask;
    logic [RAM_ADDR_WIDTH-1:0] nxt;
    step = RAM_ADDR_WIDTH'(STRB_WIDTH);
    mask = (RAM_ADDR_WIDTH'(len) + RAM_ADDR_WIDTH'(1)) << ADDR_LSB;
    mask = mask - RAM_ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = (addr & ~mask) | ((addr + step) & mask);
      default:     nxt = addr + step;
    endcase
    return nxt;
  endfunction

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Upper address bits alias and the low byte-lane bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:RAM_ADDR_WIDTH],
                              s_axi_awaddr[ADDR_LSB-1:0],
                              s_axi_araddr[ADDR_WIDTH-1:RAM_ADDR_WIDTH],
                              s_axi_araddr[ADDR_LSB-1:0]};

  // ---------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------
  logic [1:0]                wr_state;
  logic [ID_WIDTH-1:0]       wr_id;
  logic [RAM_ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]                wr_len;
  logic [7:0]                wr_cnt;
  logic [1:0]                wr_burst;
  logic                      wr_bad_burst;
  logic                      wr_bad_last;
  logic                      bvalid_q;
  logic [ID_WIDTH-1:0]       bid_q;
  logic [1:0]                bresp_q;
  logic [RAM_ADDR_WIDTH-1:0] aw_start;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      b_hs;
  logic                      wr_final;

  assign s_axi_awready = (wr_state == WR_IDLE) && !rst;
  assign s_axi_wready  = (wr_state == WR_DATA) && !rst;
  assign s_axi_bvalid  = bvalid_q && !rst;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;

  assign aw_start = {s_axi_awaddr[RAM_ADDR_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
  assign aw_hs    = s_axi_awvalid && s_axi_awready;
  assign w_hs     = s_axi_wvalid && s_axi_wready;
  assign b_hs     = s_axi_bvalid && s_axi_bready;
  assign wr_final = (wr_cnt == wr_len);

  // Write FSM: accept AW, count W beats to len, then hold B until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state    <= WR_IDLE;
      wr_cnt      <= 8'd0;
      wr_bad_last <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RESP_OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs) begin
            wr_cnt      <= 8'd0;
            wr_bad_last <= 1'b0;
            wr_state    <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            wr_cnt <= wr_cnt + 8'd1;
            if (wr_final) begin
              // Termination is by count; a missing wlast only flags an error.
              wr_state <= WR_RESP;
              bvalid_q <= 1'b1;
              bid_q    <= wr_id;
              bresp_q  <= (wr_bad_burst || wr_bad_last || !s_axi_wlast)
                          ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_wlast) begin
              wr_bad_last <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            bvalid_q <= 1'b0;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Write burst fields latched at AW; address steps on every W beat.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      wr_id        <= s_axi_awid;
      wr_addr      <= aw_start;
      wr_len       <= s_axi_awlen;
      wr_burst     <= s_axi_awburst;
      wr_bad_burst <= burst_illegal(s_axi_awburst, s_axi_awlen);
    end else if (w_hs) begin
      wr_addr <= next_addr(wr_addr, wr_len, wr_burst);
    end
  end

  // Byte-masked store of accepted W beats; illegal bursts leave the array alone.
  always_ff @(posedge clk) begin
    if (w_hs && !wr_bad_burst) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[wr_addr[RAM_ADDR_WIDTH-1:ADDR_LSB]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------
  logic [0:0]                rd_state;
  logic [RAM_ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]                rd_len;
  logic [7:0]                rd_cnt;
  logic [1:0]                rd_burst;
  logic                      rd_bad_burst;
  logic                      rvalid_q;
  logic                      rlast_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [1:0]                rresp_q;
  logic [ID_WIDTH-1:0]       rid_q;
  logic [RAM_ADDR_WIDTH-1:0] ar_start;
  logic [RAM_ADDR_WIDTH-1:0] rd_next;
  logic                      ar_bad;
  logic                      ar_hs;
  logic                      r_hs;

  assign s_axi_arready = (rd_state == RD_IDLE) && !rst;
  assign s_axi_rvalid  = rvalid_q && !rst;
  assign s_axi_rlast   = rlast_q && !rst;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;

  assign ar_start = {s_axi_araddr[RAM_ADDR_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
  assign ar_bad   = burst_illegal(s_axi_arburst, s_axi_arlen);
  assign rd_next  = next_addr(rd_addr, rd_len, rd_burst);
  assign ar_hs    = s_axi_arvalid && s_axi_arready;
  assign r_hs     = s_axi_rvalid && s_axi_rready;

  // Read FSM: the first beat is loaded at AR; each non-final R handshake loads
  // the next beat, so back-to-back handshakes run at one beat per cycle.
  // Array reads sample pre-write contents on a same-cycle write collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= 8'd0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rid_q    <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state <= RD_BURST;
            rd_cnt   <= 8'd0;
            rvalid_q <= 1'b1;
            rlast_q  <= (s_axi_arlen == 8'd0);
            rid_q    <= s_axi_arid;
            rresp_q  <= ar_bad ? RESP_SLVERR : RESP_OKAY;
            rdata_q  <= ar_bad ? '0 : mem[ar_start[RAM_ADDR_WIDTH-1:ADDR_LSB]];
          end
        end
        RD_BURST: begin
          if (r_hs) begin
            if (rlast_q) begin
              rd_state <= RD_IDLE;
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
            end else begin
              rd_cnt  <= rd_cnt + 8'd1;
              rlast_q <= ((rd_cnt + 8'd1) == rd_len);
              rdata_q <= rd_bad_burst ? '0 : mem[rd_next[RAM_ADDR_WIDTH-1:ADDR_LSB]];
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Read burst fields latched at AR; address tracks the beat on the bus.
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      rd_addr      <= ar_start;
      rd_len       <= s_axi_arlen;
      rd_burst     <= s_axi_arburst;
      rd_bad_burst <= ar_bad;
    end else if (r_hs && !rlast_q) begin
      rd_addr <= rd_next;
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed testbench for axi_ram_slave (DATA_WIDTH=128, RAM_ADDR_WIDTH=16).
module tb_axi_ram_slave;

  logic         clk;
  logic         rst;
  logic [3:0]   awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   arid;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int n_chk;
  int n_fail;

  logic [127:0] wbeats [16];
  logic [127:0] expd   [16];
  logic [127:0] rd_data[16];
  logic         rd_last[16];
  logic [1:0]   rd_resp[16];
  logic [3:0]   rd_id  [16];
  int           rd_n;
  logic [1:0]   resp;

  axi_ram_slave dut (
    .clk          (clk),
    .rst          (rst),
    .s_axi_awid   (awid),
    .s_axi_awaddr (awaddr),
    .s_axi_awlen  (awlen),
    .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wlast  (wlast),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bid    (bid),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_arid   (arid),
    .s_axi_araddr (araddr),
    .s_axi_arlen  (arlen),
    .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rid    (rid),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rlast  (rlast),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write burst using wbeats[]; last_at < 0 puts wlast on the final beat.
  task automatic wr_burst(input logic [3:0] id, input logic [63:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input logic [15:0] strb, input int last_at,
                          input int bstall, output logic [1:0] resp_o);
    int t;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin step(); t++; end
    chk("awready", awready, 1'b1);
    step();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata  = wbeats[i];
      wstrb  = strb;
      wlast  = (last_at < 0) ? (i == int'(len)) : (i == last_at);
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin step(); t++; end
      chk($sformatf("wready%0d", i), wready, 1'b1);
      step();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    t = 0;
    while (!bvalid && t < 50) begin step(); t++; end
    chk("bvalid", bvalid, 1'b1);
    chk("bid", bid, id);
    resp_o = bresp;
    for (int k = 0; k < bstall; k++) begin
      step();
      chk($sformatf("bvalid_hold%0d", k), bvalid, 1'b1);
      chk($sformatf("bid_hold%0d", k), bid, id);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 1'b0);
  endtask

  // Read burst; toggle drives rready with the repeating pattern 1,0,0,1.
  task automatic rd_burst(input logic [3:0] id, input logic [63:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input bit toggle);
    int t;
    int cyc;
    logic stalled;
    logic [127:0] held;
    rd_n = 0; stalled = 1'b0; held = '0; cyc = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin step(); t++; end
    chk("arready", arready, 1'b1);
    step();
    arvalid = 1'b0;
    while (rd_n <= int'(len) && cyc < 200) begin
      rready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (!toggle) chk($sformatf("r_throughput%0d", rd_n), rvalid, 1'b1);
      if (stalled) chk($sformatf("r_stable%0d", rd_n), rdata, held);
      stalled = 1'b0;
      if (rvalid && rready) begin
        rd_data[rd_n] = rdata;
        rd_last[rd_n] = rlast;
        rd_resp[rd_n] = rresp;
        rd_id[rd_n]   = rid;
        rd_n++;
      end else if (rvalid) begin
        stalled = 1'b1;
        held    = rdata;
      end
      step();
      cyc++;
    end
    rready = 1'b0;
    chk("rd_beats", rd_n, len + 9'd1);
    chk("rvalid_drop", rvalid, 1'b0);
    chk("arready_idle", arready, 1'b1);
  endtask

  // Compare captured beats against expd[] with the given id and response.
  task automatic chk_beats(input string pfx, input logic [3:0] id,
                           input logic [1:0] rsp, input int n);
    for (int i = 0; i < n && i < rd_n; i++) begin
      chk($sformatf("%s_rdata%0d", pfx, i), rd_data[i], expd[i]);
      chk($sformatf("%s_rlast%0d", pfx, i), rd_last[i], (i == n - 1));
      chk($sformatf("%s_rid%0d", pfx, i), rd_id[i], id);
      chk($sformatf("%s_rresp%0d", pfx, i), rd_resp[i], rsp);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) step();

    // reset state
    chk("rst_awready", awready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rdata", rdata, 128'h0);
    chk("rst_bresp", bresp, 2'b00);
    rst = 1'b0;
    step();
    chk("awready_post_rst", awready, 1'b1);
    chk("arready_post_rst", arready, 1'b1);

    // W without AW is refused
    wvalid = 1'b1; wdata = 128'h55; wstrb = 16'hFFFF; wlast = 1'b1;
    step();
    chk("w_before_aw", wready, 1'b0);
    wvalid = 1'b0; wlast = 1'b0;

    // INCR write then INCR read
    for (int i = 0; i < 4; i++) wbeats[i] = 128'hA0 + i;
    wr_burst(4'd3, 64'h100, 8'd3, 2'b01, 16'hFFFF, -1, 0, resp);
    chk("t1_bresp", resp, 2'b00);
    rd_burst(4'd5, 64'h100, 8'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) expd[i] = 128'hA0 + i;
    chk_beats("t1", 4'd5, 2'b00, 4);

    // byte strobe merge
    wbeats[0] = {128{1'b1}};
    wr_burst(4'd1, 64'h100, 8'd0, 2'b01, 16'hFFFF, -1, 0, resp);
    wbeats[0] = 128'h11;
    wr_burst(4'd1, 64'h100, 8'd0, 2'b01, 16'h0001, -1, 0, resp);
    chk("t2_bresp", resp, 2'b00);
    rd_burst(4'd2, 64'h100, 8'd0, 2'b01, 1'b0);
    expd[0] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF11;
    chk_beats("t2", 4'd2, 2'b00, 1);

    // WRAP write from 0x130 lands at 0x130,0x100,0x110,0x120
    for (int i = 0; i < 4; i++) wbeats[i] = 128'hB0 + i;
    wr_burst(4'd2, 64'h130, 8'd3, 2'b10, 16'hFFFF, -1, 0, resp);
    chk("t3_bresp", resp, 2'b00);
    rd_burst(4'd4, 64'h100, 8'd3, 2'b01, 1'b0);
    expd[0] = 128'hB1; expd[1] = 128'hB2; expd[2] = 128'hB3; expd[3] = 128'hB0;
    chk_beats("t3", 4'd4, 2'b00, 4);

    // WRAP with 3 beats is illegal: SLVERR, array untouched
    for (int i = 0; i < 3; i++) wbeats[i] = 128'hC0 + i;
    wr_burst(4'd6, 64'h100, 8'd2, 2'b10, 16'hFFFF, -1, 0, resp);
    chk("t3_wrap3_bresp", resp, 2'b10);
    rd_burst(4'd4, 64'h100, 8'd3, 2'b01, 1'b0);
    chk_beats("t3_keep", 4'd4, 2'b00, 4);

    // reserved burst read: SLVERR, zero data, full beat count
    rd_burst(4'd8, 64'h100, 8'd1, 2'b11, 1'b0);
    expd[0] = 128'h0; expd[1] = 128'h0;
    chk_beats("rsvd", 4'd8, 2'b10, 2);

    // 8-beat read with rready 1,0,0,1
    for (int i = 0; i < 8; i++) wbeats[i] = 128'hD0 + i;
    wr_burst(4'd7, 64'h300, 8'd7, 2'b01, 16'hFFFF, -1, 0, resp);
    chk("t4_bresp", resp, 2'b00);
    rd_burst(4'd9, 64'h300, 8'd7, 2'b01, 1'b1);
    for (int i = 0; i < 8; i++) expd[i] = 128'hD0 + i;
    chk_beats("t4", 4'd9, 2'b00, 8);

    // upper address bits alias onto the same store
    rd_burst(4'd1, 64'h0000_0001_0000_0310, 8'd0, 2'b01, 1'b0);
    expd[0] = 128'hD1;
    chk_beats("alias", 4'd1, 2'b00, 1);

    // early wlast: all beats taken, data written, SLVERR, B held under stall
    for (int i = 0; i < 4; i++) wbeats[i] = 128'hE0 + i;
    wr_burst(4'd9, 64'h400, 8'd3, 2'b01, 16'hFFFF, 1, 5, resp);
    chk("t5_bresp", resp, 2'b10);
    rd_burst(4'd3, 64'h400, 8'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) expd[i] = 128'hE0 + i;
    chk_beats("t5", 4'd3, 2'b00, 4);

    // FIXED write: both beats hit one word, last one wins
    wbeats[0] = 128'hF0; wbeats[1] = 128'hF1;
    wr_burst(4'd5, 64'h500, 8'd1, 2'b00, 16'hFFFF, -1, 0, resp);
    chk("fixed_bresp", resp, 2'b00);
    rd_burst(4'd5, 64'h500, 8'd0, 2'b01, 1'b0);
    expd[0] = 128'hF1;
    chk_beats("fixed", 4'd5, 2'b00, 1);

    // reset pulse mid read burst
    arid = 4'd6; araddr = 64'h300; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("t6_beat0_valid", rvalid, 1'b1);
    chk("t6_beat0", rdata, 128'hD0);
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("t6_beat1", rdata, 128'hD1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rvalid_after_rst", rvalid, 1'b0);
    step();
    chk("t6_arready", arready, 1'b1);
    chk("t6_rvalid_idle", rvalid, 1'b0);
    rd_burst(4'd7, 64'h300, 8'd7, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) expd[i] = 128'hD0 + i;
    chk_beats("t6", 4'd7, 2'b00, 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
- Single-port AXI4 slave memory model attached to one master-side port (s1/s2 position) of the 2x2 interconnect.
- Consumes the interconnect's outgoing AW/W/AR traffic and returns B/R responses.
- Serves as the default endpoint for interconnect bring-up and traffic tests.
- Read and write channels run independent FSMs sharing one byte-addressable array.

Parameters:
DATA_WIDTH  128  beat width in bits; power of two, at least 32
ADDR_WIDTH  64  AXI address width
ID_WIDTH  4  transaction ID width; IDs are echoed unchanged
RAM_ADDR_WIDTH  16  bytes of backing store = 2**RAM_ADDR_WIDTH; word index = addr[RAM_ADDR_WIDTH-1:ADDR_LSB], ADDR_LSB = log2(DATA_WIDTH/8); upper address bits ignored (aliasing)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  write start address; low ADDR_LSB bits ignored
s_axi_awlen  in  8  beats minus one
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_WIDTH  response ID
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  ID_WIDTH  read ID
s_axi_araddr  in  ADDR_WIDTH  read start address
s_axi_arlen  in  8  beats minus one
s_axi_arburst  in  2  burst type, same encoding as AW
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  read ID
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Reset: awready, wready, bvalid, arready, rvalid and rlast are 0 while rst is high; bid, bresp, rid, rdata and rresp are 0. Array contents are not cleared. Asserting rst mid-burst aborts both FSMs to IDLE with no response issued. awready and arready rise in the first cycle after rst deasserts.
- Beats are always full width (no size port). Beat address sequence:
  - FIXED: constant.
  - INCR: +DATA_WIDTH/8 per beat, wrapping modulo 2**RAM_ADDR_WIDTH.
  - WRAP: wraps within a (len+1)*DATA_WIDTH/8 byte aligned window.
- Illegal burst: type 11, or WRAP with len+1 not in {2,4,8,16}. The burst still runs its full beat count. Writes are suppressed and every response (B, or each R beat) is SLVERR with rdata 0.
- Write FSM:
  - IDLE: awready=1. On an AW handshake, latch id/addr/len/burst, clear the beat counter, go to DATA.
  - DATA: wready=1. Each W handshake writes the bytes with strb set, advances the address and increments the counter. The handshake where counter==len goes to RESP.
  - wlast check: wlast low on the final beat, or high on an earlier beat, forces bresp=SLVERR. Data is still written, and termination is by count only.
  - RESP: bvalid=1, bid=latched id; held stable until bready, then IDLE.
  - Awready is low outside IDLE: one outstanding write.
- Read FSM:
  - IDLE: arready=1. On an AR handshake, latch fields, go to BURST. The first beat is presented (rvalid=1) in the cycle after the AR handshake.
  - BURST: rdata is registered from the array. rid, rdata, rresp and rlast are held stable while rvalid && !rready.
  - On an R handshake with the beat not last, the next beat is valid in the next cycle, giving full throughput.
  - rlast=1 exactly on beat len. Its handshake returns to IDLE, and rvalid drops the following cycle unless a new AR was accepted.
  - There is at least one cycle of arready between bursts.
- Read/write collision: a read beat loaded in the same cycle as a write to the same word returns the pre-write data.
- W beats arriving before AW are not accepted (wready=0 in IDLE).

Test Plan:
- DATA_WIDTH=128: INCR write, awaddr=0x100, awlen=3, data 0xA0..0xA3, strb all ones; then INCR read, same addr/len -> bresp=00; rdata 0xA0,0xA1,0xA2,0xA3; rlast on 4th beat only; rid equals arid=5.
- Write 0x100 = all-0xFF, then write 0x100 with strb=0x0001 and data 0x11 -> read returns 0xFF..FF11.
- WRAP write, awaddr=0x130, awlen=3 -> beats land at 0x130, 0x100, 0x110, 0x120; INCR readback from 0x100 confirms. WRAP with awlen=2 -> bresp=10, array unchanged.
- Read 8-beat burst with rready toggling 1,0,0,1 each cycle -> no beat lost or duplicated; rdata stable while stalled; 8 handshakes total.
- Write with wlast asserted on beat 2 of 4 -> all 4 beats are consumed, bresp=10; bvalid held 5 cycles with bready=0 and bid stable.
- rst pulsed for one cycle mid read burst after beat 1 -> rvalid=0 the next cycle, arready=1 the cycle after, and a fresh read returns the previously written data.
